// File: rtl/serdes_rx_pattern_checker_pkg.sv
// Shared constants and FSM state encoding for the SERDES loopback RX pattern checker.
package serdes_rx_pattern_checker_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D10_2 = 8'h4A;
  localparam int         LANES = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/serdes_word_classify.sv
// Combinational classification of one 8-lane word: comma-fill match, code errors, comma lane.
// Zero latency; no flow control.
module serdes_word_classify
  import serdes_rx_pattern_checker_pkg::*;
#(
  parameter logic [7:0] COMMA_CHAR = K28_5,
  parameter logic [7:0] FILL_CHAR  = D10_2,
  parameter int         EXP_POS    = 8
) (
  input  logic [63:0] data,
  input  logic [7:0]  k,
  input  logic [7:0]  nit,
  input  logic [7:0]  disp,
  output logic        good,
  output logic        code_bad,
  output logic [2:0]  pos
);

  logic one_k;
  logic bytes_ok;

  always_comb begin
    code_bad = |(nit | disp);
    one_k    = (k != 8'd0) && ((k & (k - 8'd1)) == 8'd0);
    pos      = 3'd0;
    bytes_ok = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (k[i]) pos = 3'(i);
    end
    // With exactly one K flag set, the K lane must carry the comma and every other lane the fill.
    for (int i = 0; i < LANES; i++) begin
      if (k[i]) begin
        if (data[8*i +: 8] != COMMA_CHAR) bytes_ok = 1'b0;
      end else begin
        if (data[8*i +: 8] != FILL_CHAR) bytes_ok = 1'b0;
      end
    end
    good = !code_bad && one_k && bytes_ok && ((EXP_POS == 8) || (int'(pos) == EXP_POS));
  end

endmodule

// File: rtl/serdes_rx_pattern_checker.sv
// Comma-fill lock checker on the decoded SERDES RX stream; word at cycle n affects outputs at edge n+2.
// No backpressure: every rx_clk carries one word.
module serdes_rx_pattern_checker
  import serdes_rx_pattern_checker_pkg::*;
#(
  parameter logic [7:0] COMMA_CHAR = K28_5,
  parameter logic [7:0] FILL_CHAR  = D10_2,
  parameter int         EXP_POS    = 8,
  parameter int         LOCK_CNT   = 4,
  parameter int         LOSS_CNT   = 3,
  parameter int         CNT_W      = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rstn_i,
  input  logic [63:0]      rx_data_i,
  input  logic [7:0]       rx_char_is_k_i,
  input  logic [7:0]       rx_not_in_table_i,
  input  logic [7:0]       rx_disp_err_i,
  input  logic             cnt_clr_i,
  output logic             lock_o,
  output logic [2:0]       comma_pos_o,
  output logic             err_o,
  output logic [CNT_W-1:0] pat_err_cnt_o,
  output logic [CNT_W-1:0] code_err_cnt_o
);

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_N  = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [63:0] data_q;
  logic [7:0]  k_q, nit_q, disp_q;

  always_ff @(posedge rx_clk) begin
    if (!rx_rstn_i) begin
      data_q <= '0;
      k_q    <= '0;
      nit_q  <= '0;
      disp_q <= '0;
    end else begin
      data_q <= rx_data_i;
      k_q    <= rx_char_is_k_i;
      nit_q  <= rx_not_in_table_i;
      disp_q <= rx_disp_err_i;
    end
  end

  logic       cls_good;
  logic       cls_code_bad;
  logic [2:0] cls_pos;

  serdes_word_classify #(
    .COMMA_CHAR(COMMA_CHAR),
    .FILL_CHAR (FILL_CHAR),
    .EXP_POS   (EXP_POS)
  ) u_classify (
    .data    (data_q),
    .k       (k_q),
    .nit     (nit_q),
    .disp    (disp_q),
    .good    (cls_good),
    .code_bad(cls_code_bad),
    .pos     (cls_pos)
  );

  state_t     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [3:0] bad_cnt_q, bad_cnt_d;
  logic [2:0] pos_d;
  logic       err_d;
  logic       lock_d;
  logic       match;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    pos_d      = comma_pos_o;
    err_d      = 1'b0;
    match      = cls_good && (cls_pos == comma_pos_o);
    case (state_q)
      ST_HUNT: begin
        if (cls_good) begin
          pos_d      = cls_pos;
          good_cnt_d = 4'd1;
          bad_cnt_d  = 4'd0;
          state_d    = (LOCK_N == 4'd1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (match) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_d == LOCK_N) begin
            state_d   = ST_LOCKED;
            bad_cnt_d = 4'd0;
          end
        end else begin
          state_d    = ST_HUNT;
          good_cnt_d = 4'd0;
        end
      end
      ST_LOCKED: begin
        // A comma on a different lane is a bad word here, never a relock.
        if (match) begin
          bad_cnt_d = 4'd0;
        end else begin
          err_d     = 1'b1;
          bad_cnt_d = bad_cnt_q + 4'd1;
          if (bad_cnt_d == LOSS_N) begin
            state_d    = ST_HUNT;
            bad_cnt_d  = 4'd0;
            good_cnt_d = 4'd0;
          end
        end
      end
      default: begin
        state_d    = ST_HUNT;
        good_cnt_d = 4'd0;
        bad_cnt_d  = 4'd0;
      end
    endcase
    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rstn_i) begin
      state_q        <= ST_HUNT;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      lock_o         <= 1'b0;
      err_o          <= 1'b0;
      comma_pos_o    <= '0;
      pat_err_cnt_o  <= '0;
      code_err_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      lock_o      <= lock_d;
      err_o       <= err_d;
      comma_pos_o <= pos_d;
      // Clear beats a same-edge increment; both counters stick at all-ones.
      if (cnt_clr_i) begin
        pat_err_cnt_o  <= '0;
        code_err_cnt_o <= '0;
      end else begin
        if (err_d && (pat_err_cnt_o != '1))
          pat_err_cnt_o <= pat_err_cnt_o + CNT_ONE;
        if (cls_code_bad && (code_err_cnt_o != '1))
          code_err_cnt_o <= code_err_cnt_o + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_serdes_rx_pattern_checker.sv
// Directed bench for serdes_rx_pattern_checker: a default instance plus a narrow-counter EXP_POS=0 instance.
module tb_serdes_rx_pattern_checker;

  localparam logic [63:0] G1 = 64'h4A4A4A4A_4A4ABC4A;
  localparam logic [7:0]  K1 = 8'h02;
  localparam logic [63:0] B1 = 64'h4A4A4A4A_4A4ABC00;
  localparam logic [63:0] L3 = 64'h4A4A4A4A_BC4A4A4A;
  localparam logic [7:0]  K3 = 8'h08;
  localparam logic [63:0] L0 = 64'h4A4A4A4A_4A4A4ABC;
  localparam logic [7:0]  K0 = 8'h01;
  localparam logic [63:0] F0 = 64'h4A4A4A4A_4A4A4A4A;

  logic        rx_clk = 1'b0;
  logic        rx_rstn = 1'b0;
  logic [63:0] rx_data = '0;
  logic [7:0]  rx_k = '0, rx_nit = '0, rx_disp = '0;
  logic        cnt_clr = 1'b0;

  logic        lock1, err1, lock2, err2;
  logic [2:0]  pos1, pos2;
  logic [15:0] pat1, code1;
  logic [1:0]  pat2, code2;

  int checks = 0;
  int errors = 0;

  always #5 rx_clk = ~rx_clk;

  serdes_rx_pattern_checker u_dut (
    .rx_clk(rx_clk), .rx_rstn_i(rx_rstn), .rx_data_i(rx_data), .rx_char_is_k_i(rx_k),
    .rx_not_in_table_i(rx_nit), .rx_disp_err_i(rx_disp), .cnt_clr_i(cnt_clr),
    .lock_o(lock1), .comma_pos_o(pos1), .err_o(err1),
    .pat_err_cnt_o(pat1), .code_err_cnt_o(code1)
  );

  serdes_rx_pattern_checker #(.EXP_POS(0), .LOSS_CNT(15), .CNT_W(2)) u_dut2 (
    .rx_clk(rx_clk), .rx_rstn_i(rx_rstn), .rx_data_i(rx_data), .rx_char_is_k_i(rx_k),
    .rx_not_in_table_i(rx_nit), .rx_disp_err_i(rx_disp), .cnt_clr_i(cnt_clr),
    .lock_o(lock2), .comma_pos_o(pos2), .err_o(err2),
    .pat_err_cnt_o(pat2), .code_err_cnt_o(code2)
  );

  // Drive one word for one rx_clk cycle; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [7:0] disp);
    rx_data = d;
    rx_k    = k;
    rx_nit  = 8'h00;
    rx_disp = disp;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic reset_dut();
    rx_rstn = 1'b0;
    send(F0, 8'h00, 8'h00);
    rx_rstn = 1'b1;
  endtask

  task automatic test_reset();
    rx_rstn = 1'b0;
    send(64'hDEAD_BEEF_0123_4567, 8'hFF, 8'hFF);
    send(G1, K1, 8'h00);
    checks++; if (lock1 !== 1'b0) begin errors++; $display("FAIL rst_lock: got %0b want 0", lock1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err1); end
    checks++; if (pos1 !== 3'd0) begin errors++; $display("FAIL rst_pos: got %0d want 0", pos1); end
    checks++; if (pat1 !== 16'd0 || code1 !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0h/%0h want 0/0", pat1, code1); end
    checks++; if (lock2 !== 1'b0 || pat2 !== 2'd0 || code2 !== 2'd0) begin errors++; $display("FAIL rst_dut2: got %0b/%0d/%0d want 0/0/0", lock2, pat2, code2); end
    rx_rstn = 1'b1;
  endtask

  task automatic test_lock_acquire();
    reset_dut();
    for (int i = 1; i <= 10; i++) begin
      send(G1, K1, 8'h00);
      if (i == 4) begin
        checks++; if (lock1 !== 1'b0) begin errors++; $display("FAIL acq_early_lock: got %0b want 0", lock1); end
      end
      if (i == 5) begin
        checks++; if (lock1 !== 1'b1) begin errors++; $display("FAIL acq_lock: got %0b want 1", lock1); end
      end
    end
    checks++; if (pos1 !== 3'd1) begin errors++; $display("FAIL acq_pos: got %0d want 1", pos1); end
    checks++; if (pat1 !== 16'd0 || code1 !== 16'd0 || err1 !== 1'b0) begin errors++; $display("FAIL acq_clean: got pat=%0h code=%0h err=%0b want 0/0/0", pat1, code1, err1); end
  endtask

  task automatic test_pattern_err();
    send(B1, K1, 8'h00);
    send(B1, K1, 8'h00);
    checks++; if (err1 !== 1'b1 || pat1 !== 16'd1) begin errors++; $display("FAIL pe_first: got err=%0b pat=%0d want 1/1", err1, pat1); end
    send(G1, K1, 8'h00);
    checks++; if (err1 !== 1'b1 || pat1 !== 16'd2 || lock1 !== 1'b1) begin errors++; $display("FAIL pe_second: got err=%0b pat=%0d lock=%0b want 1/2/1", err1, pat1, lock1); end
    send(G1, K1, 8'h00);
    checks++; if (err1 !== 1'b0 || lock1 !== 1'b1) begin errors++; $display("FAIL pe_recover: got err=%0b lock=%0b want 0/1", err1, lock1); end
    send(B1, K1, 8'h00);
    send(B1, K1, 8'h00);
    send(B1, K1, 8'h00);
    checks++; if (lock1 !== 1'b1 || pat1 !== 16'd4) begin errors++; $display("FAIL pe_two_bad: got lock=%0b pat=%0d want 1/4", lock1, pat1); end
    send(G1, K1, 8'h00);
    checks++; if (lock1 !== 1'b0 || err1 !== 1'b1 || pat1 !== 16'd5) begin errors++; $display("FAIL pe_loss: got lock=%0b err=%0b pat=%0d want 0/1/5", lock1, err1, pat1); end
  endtask

  task automatic test_code_err();
    for (int i = 0; i < 6; i++) send(G1, K1, 8'h00);
    checks++; if (lock1 !== 1'b1) begin errors++; $display("FAIL ce_relock: got %0b want 1", lock1); end
    cnt_clr = 1'b1;
    send(G1, K1, 8'h00);
    cnt_clr = 1'b0;
    checks++; if (pat1 !== 16'd0 || code1 !== 16'd0) begin errors++; $display("FAIL ce_clear: got %0h/%0h want 0/0", pat1, code1); end
    send(G1, K1, 8'h10);
    send(G1, K1, 8'h00);
    checks++; if (code1 !== 16'd1 || pat1 !== 16'd1 || err1 !== 1'b1 || lock1 !== 1'b1) begin errors++; $display("FAIL ce_disp: got code=%0d pat=%0d err=%0b lock=%0b want 1/1/1/1", code1, pat1, err1, lock1); end
    send(G1, K1, 8'h00);
    checks++; if (err1 !== 1'b0 || code1 !== 16'd1) begin errors++; $display("FAIL ce_single: got err=%0b code=%0d want 0/1", err1, code1); end
  endtask

  task automatic test_verify_lane_shift();
    reset_dut();
    send(G1, K1, 8'h00);
    send(G1, K1, 8'h00);
    send(L3, K3, 8'h00);
    checks++; if (pos1 !== 3'd1 || lock1 !== 1'b0) begin errors++; $display("FAIL ls_verify: got pos=%0d lock=%0b want 1/0", pos1, lock1); end
    send(L3, K3, 8'h00);
    checks++; if (pos1 !== 3'd1 || lock1 !== 1'b0) begin errors++; $display("FAIL ls_hunt_hold: got pos=%0d lock=%0b want 1/0", pos1, lock1); end
    send(L3, K3, 8'h00);
    checks++; if (pos1 !== 3'd3) begin errors++; $display("FAIL ls_capture: got %0d want 3", pos1); end
    send(L3, K3, 8'h00);
    send(L3, K3, 8'h00);
    checks++; if (lock1 !== 1'b0) begin errors++; $display("FAIL ls_early: got %0b want 0", lock1); end
    send(L3, K3, 8'h00);
    checks++; if (lock1 !== 1'b1 || pos1 !== 3'd3) begin errors++; $display("FAIL ls_relock: got lock=%0b pos=%0d want 1/3", lock1, pos1); end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int i = 0; i < 6; i++) send(L0, K0, 8'h00);
    checks++; if (lock2 !== 1'b1 || pos2 !== 3'd0) begin errors++; $display("FAIL sat_lock: got lock=%0b pos=%0d want 1/0", lock2, pos2); end
    send(F0, 8'h00, 8'h00);
    send(F0, 8'h00, 8'h00);
    checks++; if (pat2 !== 2'd1) begin errors++; $display("FAIL sat_one: got %0d want 1", pat2); end
    send(F0, 8'h00, 8'h00);
    send(F0, 8'h00, 8'h00);
    checks++; if (pat2 !== 2'd3) begin errors++; $display("FAIL sat_max: got %0d want 3", pat2); end
    send(L0, K0, 8'h00);
    checks++; if (pat2 !== 2'd3 || err2 !== 1'b1 || lock2 !== 1'b1) begin errors++; $display("FAIL sat_hold: got pat=%0d err=%0b lock=%0b want 3/1/1", pat2, err2, lock2); end
    send(F0, 8'h00, 8'h00);
    cnt_clr = 1'b1;
    send(L0, K0, 8'h00);
    cnt_clr = 1'b0;
    checks++; if (pat2 !== 2'd0 || err2 !== 1'b1) begin errors++; $display("FAIL sat_clr_wins: got pat=%0d err=%0b want 0/1", pat2, err2); end
    send(L0, K0, 8'h00);
    checks++; if (pat2 !== 2'd0 || lock2 !== 1'b1) begin errors++; $display("FAIL sat_after_clr: got pat=%0d lock=%0b want 0/1", pat2, lock2); end
  endtask

  task automatic test_exp_pos_and_reset();
    reset_dut();
    for (int i = 0; i < 8; i++) send(G1, K1, 8'h00);
    checks++; if (lock2 !== 1'b0 || code2 !== 2'd0 || pos2 !== 3'd0) begin errors++; $display("FAIL ep_nolock: got lock=%0b code=%0d pos=%0d want 0/0/0", lock2, code2, pos2); end
    send(G1, K1, 8'h10);
    for (int i = 0; i < 3; i++) send(G1, K1, 8'h00);
    checks++; if (lock1 !== 1'b1 || code1 !== 16'd1 || pat1 !== 16'd1 || pos1 !== 3'd1) begin errors++; $display("FAIL rl_pre: got lock=%0b code=%0d pat=%0d pos=%0d want 1/1/1/1", lock1, code1, pat1, pos1); end
    rx_rstn = 1'b0;
    send(G1, K1, 8'h00);
    checks++; if (lock1 !== 1'b0 || err1 !== 1'b0 || pos1 !== 3'd0 || pat1 !== 16'd0 || code1 !== 16'd0) begin errors++; $display("FAIL rl_clear: got lock=%0b err=%0b pos=%0d pat=%0d code=%0d want all 0", lock1, err1, pos1, pat1, code1); end
    rx_rstn = 1'b1;
    send(G1, K1, 8'h00);
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_pattern_err();
    test_code_err();
    test_verify_lane_shift();
    test_saturation();
    test_exp_pos_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
